// File: rtl/inport_link_controller.sv
// Input-port link controller: counts buffered packets, requests an output
// port, drives one packet of buffer reads per grant and returns credits.
module inport_link_controller #(
  parameter int PE_DIR       = 0,
  parameter int X_POS_DIR    = 1,
  parameter int PORT_DIR     = X_POS_DIR,
  parameter int NUM_PORTS    = 5,
  parameter int DATA_FLITS   = 4,
  parameter int BUFFER_DEPTH = 20,
  parameter int PACKET_FLITS = DATA_FLITS + 1,
  parameter int MAX_PACKETS  = (PORT_DIR == PE_DIR) ? 1 : BUFFER_DEPTH / 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_strobe_din,
  input  logic [NUM_PORTS-1:0] route_request_din,
  input  logic [NUM_PORTS-1:0] transfer_strobe_din,
  output logic [NUM_PORTS-1:0] port_request_dout,
  output logic                 read_strobe_dout,
  output logic                 credit_out_dout,
  output logic                 packet_ready_dout
);

  localparam int FW = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
  localparam int SW = $clog2(MAX_PACKETS) + 1;
  localparam logic [FW-1:0] LAST = FW'(PACKET_FLITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    TRANSFER
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_PORTS-1:0] req_reg, req_nxt;
  logic [NUM_PORTS-1:0] route_low;
  logic [FW-1:0]        flit_cnt;
  logic [FW-1:0]        read_cnt, read_nxt;
  logic [SW-1:0]        packets_stored;
  logic                 credit_q;
  logic                 complete;
  logic                 done;
  logic                 found;

  assign complete = write_strobe_din && (flit_cnt == LAST);
  assign done     = (state == TRANSFER) && (read_cnt == LAST);

  // Lowest-index set bit wins when routing reports several ports.
  always_comb begin
    route_low = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (route_request_din[i] && !found) begin
        route_low[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_reg;
    read_nxt  = read_cnt;
    unique case (state)
      IDLE: begin
        if ((packets_stored != '0) && (route_request_din != '0)) begin
          req_nxt   = route_low;
          state_nxt = REQUEST;
        end
      end
      REQUEST: begin
        if ((transfer_strobe_din & req_reg) != '0) begin
          req_nxt   = '0;
          read_nxt  = '0;
          state_nxt = TRANSFER;
        end
      end
      TRANSFER: begin
        read_nxt = read_cnt + FW'(1);
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_reg  <= '0;
      read_cnt <= '0;
      credit_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_reg  <= req_nxt;
      read_cnt <= read_nxt;
      credit_q <= done;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_cnt       <= '0;
      packets_stored <= '0;
    end else begin
      if (write_strobe_din)
        flit_cnt <= complete ? '0 : flit_cnt + FW'(1);
      if (complete && !done)
        packets_stored <= packets_stored + SW'(1);
      else if (done && !complete)
        packets_stored <= packets_stored - SW'(1);
    end
  end

  assign port_request_dout = req_reg;
  assign read_strobe_dout  = (state == TRANSFER);
  assign credit_out_dout   = credit_q;
  assign packet_ready_dout = (packets_stored != '0);

endmodule

// File: tb/tb_inport_link_controller.sv
// Random-stimulus scoreboard bench for inport_link_controller.
// A transaction-level model predicts the outputs seen after every clock.
module tb_inport_link_controller;

  localparam int NP    = 5;
  localparam int PF    = 5;
  localparam int MAXP  = 4;
  localparam int NCYC  = 4000;

  typedef struct {
    logic [NP-1:0] req;
    logic          rd;
    logic          cr;
    logic          rdy;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          w;
  logic [NP-1:0] route;
  logic [NP-1:0] ts;
  logic [NP-1:0] port_request;
  logic          read_strobe;
  logic          credit_out;
  logic          packet_ready;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_req;
  int m_left;
  int m_stored;
  int m_flits;
  bit m_credit;

  inport_link_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .write_strobe_din    (w),
    .route_request_din   (route),
    .transfer_strobe_din (ts),
    .port_request_dout   (port_request),
    .read_strobe_dout    (read_strobe),
    .credit_out_dout     (credit_out),
    .packet_ready_dout   (packet_ready)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_req    = -1;
    m_left   = 0;
    m_stored = 0;
    m_flits  = 0;
    m_credit = 1'b0;
  endtask

  // One clock of the port: packets in/out, one grant -> PF reads, credit after.
  task automatic model_step();
    int old_stored;
    bit done;
    bit comp;
    old_stored = m_stored;
    done       = (m_left == 1);
    comp       = w && (m_flits == PF - 1);
    if (w) m_flits = comp ? 0 : m_flits + 1;
    m_stored = m_stored + int'(comp) - int'(done);
    m_credit = done;
    if (m_left > 0)
      m_left--;
    else if (m_req >= 0) begin
      if (ts[m_req]) begin
        m_req  = -1;
        m_left = PF;
      end
    end else if (old_stored != 0 && route != '0)
      m_req = lowest(route);
  endtask

  task automatic push_exp();
    exp_t e;
    e.req = (m_req >= 0) ? NP'(1 << m_req) : '0;
    e.rd  = (m_left > 0);
    e.cr  = m_credit;
    e.rdy = (m_stored != 0);
    q.push_back(e);
  endtask

  // Monitor: one expected output set per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = q.pop_front();
        if (port_request !== e.req || read_strobe !== e.rd ||
            credit_out !== e.cr || packet_ready !== e.rdy) begin
          miscompares++;
          $display("FAIL outputs at %0t: got req=%b rd=%b cr=%b rdy=%b want req=%b rd=%b cr=%b rdy=%b",
                   $time, port_request, read_strobe, credit_out, packet_ready,
                   e.req, e.rd, e.cr, e.rdy);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    w     = 1'b0;
    route = '0;
    ts    = '0;
    model_reset();
    push_exp();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      #1;
      if (c == 1 || (c > 20 && $urandom_range(0, 299) == 0)) begin
        reset = 1'b1;
        w     = 1'b0;
        route = '0;
        ts    = '0;
        model_reset();
        push_exp();
        #1;
        vectors++;
        if (port_request !== '0 || read_strobe !== 1'b0 ||
            credit_out !== 1'b0 || packet_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL async_reset at %0t: got req=%b rd=%b cr=%b rdy=%b want all 0",
                   $time, port_request, read_strobe, credit_out, packet_ready);
        end
        continue;
      end
      reset = 1'b0;
      w = (m_stored < MAXP) && ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       route = '0;
        1:       route = NP'(1 << $urandom_range(0, NP - 1));
        default: route = NP'($urandom_range(1, (1 << NP) - 1));
      endcase
      ts = ($urandom_range(0, 3) == 0) ? NP'($urandom_range(0, (1 << NP) - 1)) : '0;
      if (m_req >= 0 && $urandom_range(0, 3) == 0)
        ts[m_req] = 1'b0;
      else if (m_req >= 0 && $urandom_range(0, 2) == 0)
        ts[m_req] = 1'b1;
      model_step();
      push_exp();
    end
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
